// File: rtl/enc_dec_pkg.sv
// Shared constants, state encoding and popcount helper for the 16-line encoder/decoder family.
// Combinational definitions only; no latency or flow control of its own.
package enc_dec_pkg;

  localparam int N_IN   = 16;
  localparam int CODE_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  function automatic logic [CODE_W:0] popcount16(input logic [N_IN-1:0] v);
    logic [CODE_W:0] n;
    n = '0;
    for (int i = 0; i < N_IN; i++) begin
      n = n + {{CODE_W{1'b0}}, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/pri_enc_16.sv
// Combinational 16-to-4 priority encoder, lowest-first (dir_i=0) or highest-first (dir_i=1).
// Zero latency, no flow control; mask_o is the one-hot of code_o, all-zero when nothing is set.
module pri_enc_16
  import enc_dec_pkg::*;
(
  input  logic [N_IN-1:0]   vec_i,
  input  logic              dir_i,
  output logic [CODE_W-1:0] code_o,
  output logic [N_IN-1:0]   mask_o,
  output logic              any_o
);

  // The last matching index in scan order wins, so each loop walks away from the preferred end.
  always_comb begin
    code_o = '0;
    if (dir_i) begin
      for (int i = 0; i < N_IN; i++) begin
        if (vec_i[i]) code_o = CODE_W'(i);
      end
    end else begin
      for (int i = N_IN - 1; i >= 0; i--) begin
        if (vec_i[i]) code_o = CODE_W'(i);
      end
    end
  end

  assign any_o = |vec_i;

  always_comb begin
    mask_o         = '0;
    mask_o[code_o] = any_o;
  end

endmodule

// File: rtl/enc_16x4_seq.sv
// Sequential 16-to-4 encoder: accepts a multi-hot word, emits one code per beat, first code 1 cycle after accept.
// Codes hold stable under code_ready backpressure; req_ready is low for the whole burst plus no same-cycle re-accept.
module enc_16x4_seq
  import enc_dec_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [N_IN-1:0]   req,
  output logic              code_valid,
  input  logic              code_ready,
  output logic [CODE_W-1:0] code,
  output logic              code_last,
  output logic [CODE_W:0]   count,
  output logic              zero_err,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [N_IN-1:0]   pending_q, pending_d;
  logic [CODE_W:0]   count_q, count_d;
  logic              zero_q, zero_d;

  logic [CODE_W-1:0] nxt_code;
  logic [N_IN-1:0]   nxt_mask;
  logic              nxt_any;
  logic              nxt_last;

  // The encoder only ever sees the pending register, so code has no path from req.
  pri_enc_16 u_pri_enc (
    .vec_i  (pending_q),
    .dir_i  (MSB_FIRST),
    .code_o (nxt_code),
    .mask_o (nxt_mask),
    .any_o  (nxt_any)
  );

  assign nxt_last = nxt_any & ~|(pending_q & ~nxt_mask);

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    count_d   = count_q;
    zero_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          pending_d = req;
          count_d   = popcount16(req);
          zero_d    = ~|req;
          if (|req) state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (code_ready) begin
          pending_d = pending_q & ~nxt_mask;
          if (nxt_last) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      count_q   <= '0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      count_q   <= count_d;
      zero_q    <= zero_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign code_valid = (state_q == ST_EMIT);
  assign busy       = (state_q == ST_EMIT);
  assign code       = nxt_code;
  assign code_last  = nxt_last;
  assign count      = count_q;
  assign zero_err   = zero_q;

endmodule
